// File: rtl/rx_frame_dispatch.sv
// rx_frame_dispatch: buffers one received payload frame, hands it to the
// inference core, and dispatches the result back to the frame's sender.
module rx_frame_dispatch #(
    parameter int USER_DATA_BYTES = 785
) (
    input  logic        ACLK,
    input  logic        ARESET,
    // RX side
    input  logic [7:0]  RX_DATA,
    input  logic [9:0]  RX_ADDR,
    input  logic        RX_EN,
    input  logic        FRAME_READY,
    input  logic [31:0] SRC_IP_ADDRESS,
    input  logic [47:0] SRC_MAC_ADDRESS,
    input  logic [15:0] SRC_UDP_PORT,
    // TX side
    input  logic        READY_FOR_SEND,
    output logic [31:0] RECIPIENT_IP_ADDRESS,
    output logic [47:0] RECIPIENT_MAC_ADDRESS,
    output logic [15:0] RECIPIENT_UDP_PORT,
    output logic [9:0]  RECIPIENT_MESSAGE,
    output logic        START_IP_TXN,
    // inference core side
    input  logic [9:0]  NN_RD_ADDR,
    output logic [7:0]  NN_RD_DATA,
    output logic        NN_START,
    input  logic        NN_DONE,
    input  logic [9:0]  NN_RESULT,
    // status
    output logic        BUSY,
    output logic [15:0] DROPPED_FRAMES
);

    // 11 bits so that a 1024-byte frame still compares correctly against 10-bit addresses
    localparam logic [10:0] DEPTH = 11'(USER_DATA_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        INFER,
        WAIT_TX,
        SEND
    } state_t;

    state_t     state;
    logic [7:0] frame_mem [0:USER_DATA_BYTES-1];

    logic wr_in_range;
    logic rd_in_range;

    assign wr_in_range = ({1'b0, RX_ADDR} < DEPTH);
    assign rd_in_range = ({1'b0, NN_RD_ADDR} < DEPTH);
    assign BUSY        = (state != IDLE);

    // Frame buffer write port: only open while idle, so a frame under inference stays locked
    // NOTE: the buffer array has no reset; clearing it would turn the RAM into a flop array, and stored data must survive ARESET anyway.
    always_ff @(posedge ACLK) begin
        if (RX_EN && wr_in_range && (state == IDLE)) begin
            frame_mem[RX_ADDR] <= RX_DATA;
        end
    end

    // Frame buffer read port: one-cycle registered read, zero for out-of-range addresses
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            NN_RD_DATA <= 8'h00;
        end else if (rd_in_range) begin
            NN_RD_DATA <= frame_mem[NN_RD_ADDR];
        end else begin
            NN_RD_DATA <= 8'h00;
        end
    end

    // Dispatch FSM with registered strobes, reply-address latching and drop counter
    // NOTE: every register here uses non-blocking assignment so all of them update from the same pre-edge values.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state                 <= IDLE;
            NN_START              <= 1'b0;
            START_IP_TXN          <= 1'b0;
            DROPPED_FRAMES        <= 16'h0000;
            RECIPIENT_IP_ADDRESS  <= 32'h0;
            RECIPIENT_MAC_ADDRESS <= 48'h0;
            RECIPIENT_UDP_PORT    <= 16'h0;
            RECIPIENT_MESSAGE     <= 10'h0;
        end else begin
            // strobes default low so each is a single-cycle pulse
            NN_START     <= 1'b0;
            START_IP_TXN <= 1'b0;

            case (state)
                IDLE: begin
                    if (FRAME_READY) begin
                        RECIPIENT_IP_ADDRESS  <= SRC_IP_ADDRESS;
                        RECIPIENT_MAC_ADDRESS <= SRC_MAC_ADDRESS;
                        RECIPIENT_UDP_PORT    <= SRC_UDP_PORT;
                        NN_START              <= 1'b1;
                        state                 <= INFER;
                    end
                end
                INFER: begin
                    if (NN_DONE) begin
                        RECIPIENT_MESSAGE <= NN_RESULT;
                        state             <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    if (READY_FOR_SEND) begin
                        START_IP_TXN <= 1'b1;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // a frame arriving while a previous one is still in flight is counted and discarded
            if (FRAME_READY && (state != IDLE) && (DROPPED_FRAMES != 16'hFFFF)) begin
                DROPPED_FRAMES <= DROPPED_FRAMES + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_dispatch.sv
// Directed, table-driven bench for rx_frame_dispatch.
module tb_rx_frame_dispatch;

    logic        ACLK;
    logic        ARESET;
    logic [7:0]  RX_DATA;
    logic [9:0]  RX_ADDR;
    logic        RX_EN;
    logic        FRAME_READY;
    logic [31:0] SRC_IP_ADDRESS;
    logic [47:0] SRC_MAC_ADDRESS;
    logic [15:0] SRC_UDP_PORT;
    logic        READY_FOR_SEND;
    logic [31:0] RECIPIENT_IP_ADDRESS;
    logic [47:0] RECIPIENT_MAC_ADDRESS;
    logic [15:0] RECIPIENT_UDP_PORT;
    logic [9:0]  RECIPIENT_MESSAGE;
    logic        START_IP_TXN;
    logic [9:0]  NN_RD_ADDR;
    logic [7:0]  NN_RD_DATA;
    logic        NN_START;
    logic        NN_DONE;
    logic [9:0]  NN_RESULT;
    logic        BUSY;
    logic [15:0] DROPPED_FRAMES;

    int checks = 0;
    int errors = 0;

    rx_frame_dispatch #(.USER_DATA_BYTES(785)) dut (
        .ACLK                  (ACLK),
        .ARESET                (ARESET),
        .RX_DATA               (RX_DATA),
        .RX_ADDR               (RX_ADDR),
        .RX_EN                 (RX_EN),
        .FRAME_READY           (FRAME_READY),
        .SRC_IP_ADDRESS        (SRC_IP_ADDRESS),
        .SRC_MAC_ADDRESS       (SRC_MAC_ADDRESS),
        .SRC_UDP_PORT          (SRC_UDP_PORT),
        .READY_FOR_SEND        (READY_FOR_SEND),
        .RECIPIENT_IP_ADDRESS  (RECIPIENT_IP_ADDRESS),
        .RECIPIENT_MAC_ADDRESS (RECIPIENT_MAC_ADDRESS),
        .RECIPIENT_UDP_PORT    (RECIPIENT_UDP_PORT),
        .RECIPIENT_MESSAGE     (RECIPIENT_MESSAGE),
        .START_IP_TXN          (START_IP_TXN),
        .NN_RD_ADDR            (NN_RD_ADDR),
        .NN_RD_DATA            (NN_RD_DATA),
        .NN_START              (NN_START),
        .NN_DONE               (NN_DONE),
        .NN_RESULT             (NN_RESULT),
        .BUSY                  (BUSY),
        .DROPPED_FRAMES        (DROPPED_FRAMES)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // read-port vectors: address driven, data expected one cycle later
    typedef struct {
        logic [9:0] addr;
        logic [7:0] exp_data;
    } rd_vec_t;

    // per-cycle control vectors: inputs for one cycle, outputs expected after the edge
    typedef struct {
        logic       frame_ready;
        logic       nn_done;
        logic [9:0] nn_result;
        logic       rfs;
        logic       exp_nn_start;
        logic       exp_start;
        logic       exp_busy;
        logic [9:0] exp_msg;
    } ctl_vec_t;

    rd_vec_t  rd_tab  [10];
    ctl_vec_t ctl_tab [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // advance one clock and settle just after the edge
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic read_check(input string name, input logic [9:0] addr, input logic [7:0] exp);
        NN_RD_ADDR = addr;
        tick();
        check(name, 64'(NN_RD_DATA), 64'(exp));
    endtask

    initial begin
        rd_tab[0] = '{10'd0,    8'h00};
        rd_tab[1] = '{10'd1,    8'h01};
        rd_tab[2] = '{10'd255,  8'hFF};
        rd_tab[3] = '{10'd256,  8'h00};
        rd_tab[4] = '{10'd300,  8'h2C};
        rd_tab[5] = '{10'd783,  8'h0F};
        rd_tab[6] = '{10'd784,  8'h10};
        rd_tab[7] = '{10'd785,  8'h00};
        rd_tab[8] = '{10'd900,  8'h00};
        rd_tab[9] = '{10'd1023, 8'h00};

        //             fr    done  result   rfs   nn_st st    busy  msg
        ctl_tab[0] = '{1'b0, 1'b1, 10'h2A5, 1'b1, 1'b0, 1'b0, 1'b1, 10'h2A5}; // INFER -> WAIT_TX
        ctl_tab[1] = '{1'b0, 1'b1, 10'h111, 1'b1, 1'b0, 1'b1, 1'b1, 10'h2A5}; // -> SEND, late NN_DONE ignored
        ctl_tab[2] = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 10'h2A5}; // frame during SEND dropped
        ctl_tab[3] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h2A5}; // idle
        ctl_tab[4] = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b1, 10'h2A5}; // new frame accepted
        ctl_tab[5] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 10'h2A5}; // INFER, NN_START gone
        ctl_tab[6] = '{1'b0, 1'b1, 10'h007, 1'b0, 1'b0, 1'b0, 1'b1, 10'h007}; // -> WAIT_TX, TX not ready

        ARESET          = 1'b1;
        RX_DATA         = 8'h00;
        RX_ADDR         = 10'd0;
        RX_EN           = 1'b0;
        FRAME_READY     = 1'b0;
        SRC_IP_ADDRESS  = 32'h0;
        SRC_MAC_ADDRESS = 48'h0;
        SRC_UDP_PORT    = 16'h0;
        READY_FOR_SEND  = 1'b0;
        NN_RD_ADDR      = 10'd0;
        NN_DONE         = 1'b0;
        NN_RESULT       = 10'h0;

        // reset state
        repeat (2) tick();
        check("rst_busy",     64'(BUSY),                 64'd0);
        check("rst_nn_start", 64'(NN_START),             64'd0);
        check("rst_start",    64'(START_IP_TXN),         64'd0);
        check("rst_dropped",  64'(DROPPED_FRAMES),       64'd0);
        check("rst_ip",       64'(RECIPIENT_IP_ADDRESS), 64'd0);
        check("rst_msg",      64'(RECIPIENT_MESSAGE),    64'd0);
        check("rst_rd_data",  64'(NN_RD_DATA),           64'd0);
        ARESET = 1'b0;

        // NN_DONE while idle is ignored
        NN_DONE   = 1'b1;
        NN_RESULT = 10'h3FF;
        tick();
        NN_DONE = 1'b0;
        check("idle_done_msg",  64'(RECIPIENT_MESSAGE), 64'd0);
        check("idle_done_busy", 64'(BUSY),              64'd0);

        // fill the frame; the last byte shares its cycle with FRAME_READY
        for (int i = 0; i < 785; i++) begin
            RX_EN   = 1'b1;
            RX_ADDR = 10'(i);
            RX_DATA = 8'(i);
            if (i == 784) begin
                FRAME_READY     = 1'b1;
                SRC_IP_ADDRESS  = 32'h0A00_0002;
                SRC_MAC_ADDRESS = 48'h0123_4567_89AB;
                SRC_UDP_PORT    = 16'h1234;
            end
            tick();
        end
        RX_EN       = 1'b0;
        FRAME_READY = 1'b0;
        check("accept_nn_start", 64'(NN_START),              64'd1);
        check("accept_busy",     64'(BUSY),                  64'd1);
        check("accept_ip",       64'(RECIPIENT_IP_ADDRESS),  64'h0A00_0002);
        check("accept_mac",      64'(RECIPIENT_MAC_ADDRESS), 64'h0123_4567_89AB);
        check("accept_port",     64'(RECIPIENT_UDP_PORT),    64'h1234);
        NN_RD_ADDR = 10'd784;
        tick();
        check("nn_start_pulse", 64'(NN_START),   64'd0);
        check("rd_784_first",   64'(NN_RD_DATA), 64'h10);
        check("infer_busy",     64'(BUSY),       64'd1);

        // read port table, including out-of-range addresses
        for (int i = 0; i < 10; i++) begin
            read_check($sformatf("rd_tab[%0d]", i), rd_tab[i].addr, rd_tab[i].exp_data);
        end

        // frames and writes during INFER are dropped / ignored
        SRC_IP_ADDRESS  = 32'hDEAD_BEEF;
        SRC_MAC_ADDRESS = 48'hFFFF_FFFF_FFFF;
        SRC_UDP_PORT    = 16'hBEEF;
        for (int k = 0; k < 3; k++) begin
            FRAME_READY = 1'b1;
            RX_EN       = 1'b1;
            RX_ADDR     = 10'd0;
            RX_DATA     = 8'hFF;
            tick();
            FRAME_READY = 1'b0;
            RX_EN       = 1'b0;
            tick();
        end
        check("drop_count",   64'(DROPPED_FRAMES),        64'd3);
        check("drop_ip",      64'(RECIPIENT_IP_ADDRESS),  64'h0A00_0002);
        check("drop_mac",     64'(RECIPIENT_MAC_ADDRESS), 64'h0123_4567_89AB);
        check("drop_port",    64'(RECIPIENT_UDP_PORT),    64'h1234);
        check("drop_busy",    64'(BUSY),                  64'd1);
        read_check("locked_addr0", 10'd0, 8'h00);

        // cycle-by-cycle dispatch table
        SRC_IP_ADDRESS = 32'h0A00_0003;
        for (int i = 0; i < 7; i++) begin
            FRAME_READY    = ctl_tab[i].frame_ready;
            NN_DONE        = ctl_tab[i].nn_done;
            NN_RESULT      = ctl_tab[i].nn_result;
            READY_FOR_SEND = ctl_tab[i].rfs;
            tick();
            check($sformatf("ctl[%0d].nn_start", i), 64'(NN_START),          64'(ctl_tab[i].exp_nn_start));
            check($sformatf("ctl[%0d].start", i),    64'(START_IP_TXN),      64'(ctl_tab[i].exp_start));
            check($sformatf("ctl[%0d].busy", i),     64'(BUSY),              64'(ctl_tab[i].exp_busy));
            check($sformatf("ctl[%0d].msg", i),      64'(RECIPIENT_MESSAGE), 64'(ctl_tab[i].exp_msg));
        end
        FRAME_READY    = 1'b0;
        NN_DONE        = 1'b0;
        READY_FOR_SEND = 1'b0;
        check("send_drop_count", 64'(DROPPED_FRAMES),       64'd4);
        check("second_ip",       64'(RECIPIENT_IP_ADDRESS), 64'h0A00_0003);

        // WAIT_TX holds while the TX stage is not ready
        for (int c = 0; c < 50; c++) begin
            tick();
            check("wait_no_start", 64'(START_IP_TXN), 64'd0);
        end
        check("wait_busy", 64'(BUSY), 64'd1);
        READY_FOR_SEND = 1'b1;
        tick();
        check("wait_release_start", 64'(START_IP_TXN), 64'd1);
        tick();
        check("wait_pulse_end",  64'(START_IP_TXN), 64'd0);
        check("wait_back_idle",  64'(BUSY),         64'd0);
        tick();
        check("wait_single_pulse", 64'(START_IP_TXN), 64'd0);
        READY_FOR_SEND = 1'b0;

        // out-of-range write is discarded without aliasing
        RX_EN   = 1'b1;
        RX_ADDR = 10'd900;
        RX_DATA = 8'hAB;
        tick();
        RX_EN = 1'b0;
        read_check("oor_900",   10'd900, 8'h00);
        read_check("alias_388", 10'd388, 8'h84);
        read_check("alias_115", 10'd115, 8'h73);

        // reset during WAIT_TX aborts the transaction
        FRAME_READY    = 1'b1;
        SRC_IP_ADDRESS = 32'h0A00_0004;
        tick();
        FRAME_READY = 1'b0;
        tick();
        NN_DONE   = 1'b1;
        NN_RESULT = 10'h155;
        tick();
        NN_DONE = 1'b0;
        tick();
        check("pre_rst_busy", 64'(BUSY),              64'd1);
        check("pre_rst_msg",  64'(RECIPIENT_MESSAGE), 64'h155);
        ARESET         = 1'b1;
        READY_FOR_SEND = 1'b1;
        FRAME_READY    = 1'b1;
        NN_RD_ADDR     = 10'd784;
        tick();
        ARESET      = 1'b0;
        FRAME_READY = 1'b0;
        check("abort_busy",     64'(BUSY),                  64'd0);
        check("abort_nn_start", 64'(NN_START),              64'd0);
        check("abort_start",    64'(START_IP_TXN),          64'd0);
        check("abort_dropped",  64'(DROPPED_FRAMES),        64'd0);
        check("abort_ip",       64'(RECIPIENT_IP_ADDRESS),  64'd0);
        check("abort_mac",      64'(RECIPIENT_MAC_ADDRESS), 64'd0);
        check("abort_port",     64'(RECIPIENT_UDP_PORT),    64'd0);
        check("abort_msg",      64'(RECIPIENT_MESSAGE),     64'd0);
        check("abort_rd_data",  64'(NN_RD_DATA),            64'd0);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("abort_no_start", 64'(START_IP_TXN), 64'd0);
            check("abort_idle",     64'(BUSY),         64'd0);
        end
        READY_FOR_SEND = 1'b0;
        read_check("kept_784", 10'd784, 8'h10);
        read_check("kept_0",   10'd0,   8'h00);
        read_check("kept_500", 10'd500, 8'hF4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
